// File: rtl/hotp_truncate.sv
// HOTP dynamic truncation, modulo 10^DIGITS reduction and BCD conversion of an HMAC-SHA1 digest.
// Optional ASCII digit output enabled by defining OTP_ASCII_EN.
module hotp_truncate #(
    parameter int unsigned DIGITS = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [159:0] hash,
    input  logic         start,
    output logic [26:0]  otp,
    output logic [31:0]  bcd,
`ifdef OTP_ASCII_EN
    output logic [63:0]  ascii,
`endif
    output logic         done
);

    if (DIGITS < 6 || DIGITS > 8) begin : g_bad_digits
        $error("hotp_truncate: DIGITS must be in 6..8");
    end

    localparam logic [27:0] Modulus = 28'(10 ** DIGITS);

    typedef enum logic [1:0] {StIdle, StTrunc, StMod, StBcd} state_e;

    state_e        state_q, state_d;
    logic [159:0]  hash_q;
    logic [30:0]   sbits_q;
    logic [27:0]   rem_q;
    logic [4:0]    count_q;
    logic [26:0]   remainder_q;
    logic [31:0]   dd_q;
    logic [26:0]   otp_q;
    logic [31:0]   bcd_q;
`ifdef OTP_ASCII_EN
    logic [63:0]   ascii_q;
    logic [63:0]   ascii_next;
`endif

    logic [7:0]    trunc_shamt;
    logic [30:0]   trunc_word;
    logic [27:0]   rem_shift;
    logic [27:0]   rem_next;
    logic [31:0]   dd_adj;
    logic [31:0]   dd_next;
    logic [31:0]   bcd_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StTrunc;
            StTrunc: state_d = StMod;
            StMod:   if (count_q == 5'd0) state_d = StBcd;
            StBcd:   if (count_q == 5'd0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Byte[offset] sits at bits 159-8*offset; shift the 4-byte window down to bit 0.
    always_comb begin
        trunc_shamt = 8'd128 - {1'b0, hash_q[3:0], 3'b000};
        trunc_word  = 31'(hash_q >> trunc_shamt);
    end

    always_comb begin
        rem_shift = (rem_q << 1) | 28'(sbits_q[count_q]);
        rem_next  = (rem_shift >= Modulus) ? (rem_shift - Modulus) : rem_shift;
    end

    always_comb begin
        dd_adj = dd_q;
        for (int unsigned i = 0; i < 8; i++) begin
            if (dd_q[4*i +: 4] >= 4'd5) begin
                dd_adj[4*i +: 4] = dd_q[4*i +: 4] + 4'd3;
            end
        end
        dd_next = (dd_adj << 1) | 32'(remainder_q[count_q]);
    end

    always_comb begin
        bcd_next = '0;
`ifdef OTP_ASCII_EN
        ascii_next = '0;
`endif
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < DIGITS) begin
                bcd_next[4*i +: 4] = dd_next[4*i +: 4];
`ifdef OTP_ASCII_EN
                ascii_next[8*i +: 8] = 8'h30 + {4'h0, dd_next[4*i +: 4]};
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hash_q      <= '0;
            sbits_q     <= '0;
            rem_q       <= '0;
            count_q     <= '0;
            remainder_q <= '0;
            dd_q        <= '0;
            otp_q       <= '0;
            bcd_q       <= '0;
`ifdef OTP_ASCII_EN
            ascii_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) hash_q <= hash;
                end
                StTrunc: begin
                    sbits_q <= trunc_word;
                    rem_q   <= '0;
                    count_q <= 5'd30;
                end
                StMod: begin
                    rem_q   <= rem_next;
                    count_q <= count_q - 5'd1;
                    if (count_q == 5'd0) begin
                        remainder_q <= rem_next[26:0];
                        dd_q        <= '0;
                        count_q     <= 5'd26;
                    end
                end
                StBcd: begin
                    dd_q    <= dd_next;
                    count_q <= count_q - 5'd1;
                    if (count_q == 5'd0) begin
                        otp_q <= remainder_q;
                        bcd_q <= bcd_next;
`ifdef OTP_ASCII_EN
                        ascii_q <= ascii_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign otp  = otp_q;
    assign bcd  = bcd_q;
    assign done = (state_q == StIdle);
`ifdef OTP_ASCII_EN
    assign ascii = ascii_q;
`endif

endmodule
